// File: rtl/lutram_test_pkg.sv
// Shared state encodings, pattern codes and expected-bit helper for the LUTRAM test blocks.
package lutram_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  localparam logic [1:0] PAT_ADDR0  = 2'd0;
  localparam logic [1:0] PAT_NADDR0 = 2'd1;
  localparam logic [1:0] PAT_PARITY = 2'd2;

  // Unused upper address bits must be zero so parity covers only the real address.
  function automatic logic exp_bit(input logic [31:0] addr, input logic [1:0] pattern);
    logic bit_v;
    case (pattern)
      PAT_ADDR0:  bit_v = addr[0];
      PAT_NADDR0: bit_v = ~addr[0];
      PAT_PARITY: bit_v = ^addr;
      default:    bit_v = addr[0];
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/lutram_rd_pipe.sv
// Tick-enabled delay line of {valid, addr, exp}, aligning issued reads with returning read data.
module lutram_rd_pipe #(
  parameter int unsigned A_WIDTH = 5,
  parameter int unsigned DEPTH   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               push_valid_i,
  input  logic [A_WIDTH-1:0] push_addr_i,
  input  logic               push_exp_i,
  output logic               tail_valid_o,
  output logic [A_WIDTH-1:0] tail_addr_o,
  output logic               tail_exp_o
);

  logic [DEPTH-1:0]         valid_r;
  logic [DEPTH-1:0]         exp_r;
  logic [DEPTH*A_WIDTH-1:0] addr_r;

  // Shift one stage per tick; the oldest entry falls off the top.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= '0;
      exp_r   <= '0;
      addr_r  <= '0;
    end else if (tick_i) begin
      valid_r <= DEPTH'({valid_r, push_valid_i});
      exp_r   <= DEPTH'({exp_r, push_exp_i});
      addr_r  <= (DEPTH*A_WIDTH)'({addr_r, push_addr_i});
    end
  end

  assign tail_valid_o = valid_r[DEPTH-1];
  assign tail_exp_o   = exp_r[DEPTH-1];
  assign tail_addr_o  = addr_r[DEPTH*A_WIDTH-1 -: A_WIDTH];

endmodule

// File: rtl/lutram_rd_checker.sv
// Read-side LUTRAM checker: walks every address, compares against the stored pattern,
// and reports pass/fail, a saturating error count and the first failing address.
module lutram_rd_checker
  import lutram_test_pkg::*;
#(
  parameter int unsigned A_WIDTH    = 5,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned PATTERN    = 0,
  parameter int unsigned ERR_W      = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               start_i,
  output logic [A_WIDTH-1:0] addr_o,
  input  logic               rd_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [ERR_W-1:0]   err_count_o,
  output logic               first_err_valid_o,
  output logic [A_WIDTH-1:0] first_err_addr_o
);

  localparam logic [A_WIDTH-1:0] ADDR_LAST  = '1;
  localparam logic [A_WIDTH-1:0] ADDR_ZERO  = '0;
  localparam logic [A_WIDTH-1:0] ADDR_ONE   = A_WIDTH'(1);
  localparam logic [ERR_W-1:0]   ERR_MAX    = '1;
  localparam logic [ERR_W-1:0]   ERR_ZERO   = '0;
  localparam logic [ERR_W-1:0]   ERR_ONE    = ERR_W'(1);
  localparam logic [1:0]         PAT_SEL    = 2'(PATTERN);
  localparam logic [1:0]         DRAIN_INIT = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

  rd_state_e          state_r, state_s;
  logic [A_WIDTH-1:0] addr_r, addr_s;
  logic [1:0]         drain_r, drain_s;
  logic [ERR_W-1:0]   err_r, err_s;
  logic               fev_r, fev_s;
  logic [A_WIDTH-1:0] fea_r, fea_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               pass_r, pass_s;

  logic               push_valid_s;
  logic               push_exp_s;
  logic               tail_valid_s;
  logic [A_WIDTH-1:0] tail_addr_s;
  logic               tail_exp_s;
  logic               in_pass_s;
  logic               mismatch_s;

  assign push_valid_s = tick_i & (state_r == ST_READ);
  assign push_exp_s   = exp_bit(32'(addr_r), PAT_SEL);

  // With zero latency the read data belongs to the address being issued right now.
  if (RD_LATENCY == 0) begin : g_no_pipe
    assign tail_valid_s = push_valid_s;
    assign tail_addr_s  = addr_r;
    assign tail_exp_s   = push_exp_s;
  end else begin : g_pipe
    lutram_rd_pipe #(
      .A_WIDTH (A_WIDTH),
      .DEPTH   (RD_LATENCY)
    ) u_pipe (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .tick_i       (tick_i),
      .push_valid_i (push_valid_s),
      .push_addr_i  (addr_r),
      .push_exp_i   (push_exp_s),
      .tail_valid_o (tail_valid_s),
      .tail_addr_o  (tail_addr_s),
      .tail_exp_o   (tail_exp_s)
    );
  end

  assign in_pass_s  = (state_r == ST_READ) | (state_r == ST_DRAIN);
  assign mismatch_s = tick_i & in_pass_s & tail_valid_s & (rd_data_i != tail_exp_s);

  // Next-state, address walk, error accounting and output decode.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    drain_s = drain_r;
    err_s   = err_r;
    fev_s   = fev_r;
    fea_s   = fea_r;
    if (tick_i) begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_s = ST_READ;
            addr_s  = ADDR_ZERO;
            err_s   = ERR_ZERO;
            fev_s   = 1'b0;
            fea_s   = ADDR_ZERO;
          end else begin
            state_s = state_r;
          end
        end
        ST_READ: begin
          addr_s = addr_r + ADDR_ONE;
          if (addr_r == ADDR_LAST) begin
            if (RD_LATENCY == 0) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_DRAIN;
              drain_s = DRAIN_INIT;
            end
          end else begin
            state_s = ST_READ;
          end
        end
        ST_DRAIN: begin
          if (drain_r == 2'd0) begin
            state_s = ST_DONE;
          end else begin
            drain_s = drain_r - 2'd1;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
      // Compares only happen in READ/DRAIN, so they never collide with the start-tick clear.
      if (mismatch_s) begin
        if (err_r != ERR_MAX) begin
          err_s = err_r + ERR_ONE;
        end else begin
          err_s = err_r;
        end
        if (!fev_r) begin
          fev_s = 1'b1;
          fea_s = tail_addr_s;
        end else begin
          fea_s = fea_r;
        end
      end else begin
        err_s = err_s;
      end
    end else begin
      state_s = state_r;
    end
    busy_s = (state_s == ST_READ) | (state_s == ST_DRAIN);
    done_s = (state_s == ST_DONE);
    pass_s = (state_s == ST_DONE) & (err_s == ERR_ZERO);
  end

  // State and result registers; outputs are taken straight from these.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      drain_r <= 2'd0;
      err_r   <= '0;
      fev_r   <= 1'b0;
      fea_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      drain_r <= drain_s;
      err_r   <= err_s;
      fev_r   <= fev_s;
      fea_r   <= fea_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  assign addr_o            = addr_r;
  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign pass_o            = pass_r;
  assign err_count_o       = err_r;
  assign first_err_valid_o = fev_r;
  assign first_err_addr_o  = fea_r;

endmodule

// File: tb/tb_lutram_rd_checker.sv
// Scoreboard bench: three checker configurations run passes against a behavioural RAM model.
module tb_lutram_rd_checker;

  localparam int N = 32;

  typedef struct {
    int err;
    int fev;
    int fea;
    int pass;
    int done_tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       rd_a    [3];
  logic [4:0] addr_a  [3];
  logic       busy_a  [3];
  logic       done_a  [3];
  logic       pass_a  [3];
  logic       fev_a   [3];
  logic [4:0] fea_a   [3];
  logic [5:0] err_a   [3];
  logic [5:0] err0;
  logic [2:0] err1;
  logic [2:0] err2;

  assign err_a[0] = err0;
  assign err_a[1] = {3'b000, err1};
  assign err_a[2] = {3'b000, err2};

  lutram_rd_checker #(.A_WIDTH(5), .RD_LATENCY(1), .PATTERN(0), .ERR_W(6)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .start_i(start), .addr_o(addr_a[0]),
    .rd_data_i(rd_a[0]), .busy_o(busy_a[0]), .done_o(done_a[0]), .pass_o(pass_a[0]),
    .err_count_o(err0), .first_err_valid_o(fev_a[0]), .first_err_addr_o(fea_a[0]));

  lutram_rd_checker #(.A_WIDTH(5), .RD_LATENCY(3), .PATTERN(2), .ERR_W(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .start_i(start), .addr_o(addr_a[1]),
    .rd_data_i(rd_a[1]), .busy_o(busy_a[1]), .done_o(done_a[1]), .pass_o(pass_a[1]),
    .err_count_o(err1), .first_err_valid_o(fev_a[1]), .first_err_addr_o(fea_a[1]));

  lutram_rd_checker #(.A_WIDTH(5), .RD_LATENCY(0), .PATTERN(1), .ERR_W(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .start_i(start), .addr_o(addr_a[2]),
    .rd_data_i(rd_a[2]), .busy_o(busy_a[2]), .done_o(done_a[2]), .pass_o(pass_a[2]),
    .err_count_o(err2), .first_err_valid_o(fev_a[2]), .first_err_addr_o(fea_a[2]));

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         tick_cnt = 0;
  int         phase = 0;
  int         tick_div = 1;
  logic [31:0] mem [3];
  int         hist [3][3];
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       q2[$];

  function automatic int lat_of(input int k);
    case (k)
      0: return 1;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int pat_of(input int k);
    case (k)
      0: return 0;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int errw_of(input int k);
    return (k == 0) ? 6 : 3;
  endfunction

  function automatic logic ref_exp(input int a, input int p);
    logic [4:0] av;
    av = a[4:0];
    case (p)
      0: return av[0];
      1: return ~av[0];
      default: return ^av;
    endcase
  endfunction

  function automatic logic [31:0] good_word(input int k);
    logic [31:0] w;
    for (int a = 0; a < N; a++) w[a] = ref_exp(a, pat_of(k));
    return w;
  endfunction

  // Whole-pass result from the RAM contents: ascending walk, so the first error is the lowest bad address.
  function automatic exp_t ref_pass(input int k, input logic [31:0] m, input int start_tick);
    exp_t r;
    int errs;
    int first;
    int cap;
    errs  = 0;
    first = -1;
    for (int a = 0; a < N; a++) begin
      if (m[a] != ref_exp(a, pat_of(k))) begin
        errs++;
        if (first < 0) first = a;
      end
    end
    cap         = (1 << errw_of(k)) - 1;
    r.err       = (errs > cap) ? cap : errs;
    r.fev       = (errs > 0) ? 1 : 0;
    r.fea       = (first < 0) ? 0 : first;
    r.pass      = (errs == 0) ? 1 : 0;
    r.done_tick = start_tick + 1 + N + lat_of(k);
    return r;
  endfunction

  function automatic int sb_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int k, output exp_t e);
    case (k)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic check(input string name, input int k, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d, required %0d", name, k, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_addr"},  k, int'(addr_a[k]), 0);
      check({tag, "_busy"},  k, int'(busy_a[k]), 0);
      check({tag, "_done"},  k, int'(done_a[k]), 0);
      check({tag, "_pass"},  k, int'(pass_a[k]), 0);
      check({tag, "_err"},   k, int'(err_a[k]),  0);
      check({tag, "_fev"},   k, int'(fev_a[k]),  0);
      check({tag, "_fea"},   k, int'(fea_a[k]),  0);
    end
  endtask

  // One clock: drive tick/start and the RAM read data, then check address hold on stall cycles.
  task automatic step(input logic st, input logic real_start, output logic ticked);
    logic [4:0] prev_addr [3];
    exp_t e;
    @(negedge clk);
    tick  = ((phase % tick_div) == 0);
    phase = phase + 1;
    start = st;
    for (int k = 0; k < 3; k++) begin
      if (lat_of(k) == 0) rd_a[k] = mem[k][addr_a[k]];
      else                rd_a[k] = mem[k][hist[k][lat_of(k) - 1]];
      prev_addr[k] = addr_a[k];
      if (tick) begin
        hist[k][2] = hist[k][1];
        hist[k][1] = hist[k][0];
        hist[k][0] = int'(addr_a[k]);
      end
      if (tick && st && real_start) begin
        e = ref_pass(k, mem[k], tick_cnt);
        sb_push(k, e);
      end
    end
    ticked = tick;
    @(posedge clk);
    if (tick) tick_cnt = tick_cnt + 1;
    #1;
    if (!ticked) begin
      for (int k = 0; k < 3; k++) check("addr_hold", k, int'(addr_a[k]), int'(prev_addr[k]));
    end
  endtask

  task automatic issue_start();
    logic tk;
    tk = 1'b0;
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) step(1'b0, 1'b0, tk);
    tk = 1'b0;
    while (!tk) step(1'b1, 1'b1, tk);
  endtask

  task automatic wait_done(input logic spur);
    logic tk;
    logic sp;
    int   since;
    int   guard;
    since = 0;
    guard = 0;
    do begin
      sp = spur && (since >= 3) && (since <= 28) && ($urandom_range(0, 7) == 0);
      step(sp, 1'b0, tk);
      if (tk) since++;
      guard++;
    end while (!(done_a[0] && done_a[1] && done_a[2]) && guard < 400);
    if (!(done_a[0] && done_a[1] && done_a[2])) begin
      n_cmp++;
      n_fail++;
      $display("FAIL pass_timeout: got done=%b%b%b after %0d clocks, required all done",
               done_a[0], done_a[1], done_a[2], guard);
      apply_reset();
    end
    step(1'b0, 1'b0, tk);
  endtask

  task automatic run_pass(input logic spur);
    issue_start();
    wait_done(spur);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    tick  = 1'b0;
    start = 1'b0;
    #1 rst = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    q2.delete();
    #1 rst = 1'b0;
  endtask

  task automatic load_good();
    for (int k = 0; k < 3; k++) mem[k] = good_word(k);
  endtask

  // Monitor: whenever a done rises, pop the expected pass result and compare.
  initial begin
    logic prev_done [3];
    exp_t e;
    for (int k = 0; k < 3; k++) prev_done[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst && done_a[k] === 1'b1 && !prev_done[k]) begin
          if (sb_size(k) == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done inst%0d: got done with no pass pending, required no done", k);
          end else begin
            sb_pop(k, e);
            check("err_count", k, int'(err_a[k]), e.err);
            check("first_err_valid", k, int'(fev_a[k]), e.fev);
            check("first_err_addr", k, int'(fea_a[k]), e.fea);
            check("pass", k, int'(pass_a[k]), e.pass);
            check("done_tick", k, tick_cnt, e.done_tick);
            check("busy_at_done", k, int'(busy_a[k]), 0);
          end
        end
        prev_done[k] = done_a[k];
      end
    end
  end

  initial begin
    logic tk;
    int   guard;
    int   mode;
    for (int k = 0; k < 3; k++) begin
      rd_a[k] = 1'b0;
      mem[k]  = 32'h0000_0000;
      for (int j = 0; j < 3; j++) hist[k][j] = 0;
    end
    #1 rst = 1'b1;
    #2;
    check_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    tick_div = 1;
    load_good();
    run_pass(1'b0);

    load_good();
    for (int k = 0; k < 3; k++) mem[k][7] = ~mem[k][7];
    run_pass(1'b0);

    for (int k = 0; k < 3; k++) mem[k] = 32'h0000_0000;
    run_pass(1'b0);

    for (int k = 0; k < 3; k++) mem[k] = 32'hFFFF_FFFF;
    run_pass(1'b0);

    tick_div = 4;
    load_good();
    run_pass(1'b0);

    // Reset in the middle of READ, then a clean restart with stray starts.
    tick_div = 1;
    load_good();
    issue_start();
    guard = 0;
    while (addr_a[0] != 5'd12 && guard < 100) begin
      step(1'b0, 1'b0, tk);
      guard++;
    end
    check("reached_addr12", 0, int'(addr_a[0]), 12);
    @(negedge clk);
    tick  = 1'b0;
    start = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_reset("midpass_reset");
    q0.delete();
    q1.delete();
    q2.delete();
    #1 rst = 1'b0;
    run_pass(1'b1);

    for (int i = 0; i < 12; i++) begin
      tick_div = int'($urandom_range(1, 4));
      mode = int'($urandom_range(0, 3));
      load_good();
      for (int k = 0; k < 3; k++) begin
        case (mode)
          1: mem[k][$urandom_range(0, 31)] = ~mem[k][$urandom_range(0, 31)];
          2: mem[k] = $urandom;
          3: mem[k] = mem[k] ^ ($urandom & $urandom);
          default: mem[k] = mem[k];
        endcase
      end
      run_pass(1'b1);
    end

    repeat (4) step(1'b0, 1'b0, tk);
    for (int k = 0; k < 3; k++) check("scoreboard_empty", k, sb_size(k), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
